// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: generic stage-to-stage pipeline register with valid/ready
// backpressure, a 2-entry skid buffer, synchronous flush and bubble zeroing.
//
// Optional feature macro: PIPE_STALL_CNT_EN
//   defined   -> saturating stall counter on stall_cnt_o (cleared only by reset)
//   undefined -> no counter flops, stall_cnt_o tied to 0
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active high
//   flush_i      squash all held entries, drop this cycle's input
//   in_valid_i   upstream presents an entry
//   in_ready_o   stage can accept (registered state and reset only)
//   in_data_i    upstream payload
//   in_ctrl_i    upstream control fields
//   out_valid_o  head entry valid
//   out_ready_i  downstream accepts the head
//   out_data_o   head payload, holds its last value while empty
//   out_ctrl_o   head control, forced to zero while out_valid_o is low
//   occupancy_o  entries held: 0, 1 or 2
//   stall_cnt_o  cycles with out_valid_o & !out_ready_i
module elastic_pipe_reg #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Encoding equals the number of held entries so occupancy is the state itself.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic in_fire;
    logic out_fire;

    // in_ready depends only on registered state (plus reset), never on out_ready_i.
    assign in_ready_o  = (state_q != StFull) & ~rst_i;
    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = main_data_q;
    assign out_ctrl_o  = out_valid_o ? main_ctrl_q : '0;
    assign occupancy_o = state_q;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush_i) begin
            // A same-cycle out_fire has already been consumed downstream; the
            // incoming entry is dropped. Data registers are left untouched.
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d     = StOne;
                        main_data_d = in_data_i;
                        main_ctrl_d = in_ctrl_i;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data_i;
                        main_ctrl_d = in_ctrl_i;
                    end else if (in_fire) begin
                        state_d     = StFull;
                        skid_data_d = in_data_i;
                        skid_ctrl_d = in_ctrl_i;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // in_ready_o is low here, so only the drain path exists.
                    if (out_fire) begin
                        state_d     = StOne;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating; flush deliberately does not clear it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Self-checking bench for elastic_pipe_reg: a reset/backpressure vector table,
// hand-written flush and stall-counter sequences, and a random phase, all
// checked against a FIFO scoreboard of accepted entries.
module tb_elastic_pipe_reg;

    localparam int unsigned DW = 48;
    localparam int unsigned CW = 8;
    localparam int unsigned NW = 4;
`ifdef PIPE_STALL_CNT_EN
    localparam int unsigned STALL_MAX = 15;
`else
    localparam int unsigned STALL_MAX = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_i, flush_i, in_valid_i, in_ready_o;
    logic [DW-1:0] in_data_i, out_data_o;
    logic [CW-1:0] in_ctrl_i, out_ctrl_o;
    logic          out_valid_o, out_ready_i;
    logic [1:0]    occupancy_o;
    logic [NW-1:0] stall_cnt_o;

    always #5 clk = ~clk;

    elastic_pipe_reg #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .CNT_W  (NW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_ctrl_i   (in_ctrl_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_ctrl_o  (out_ctrl_o),
        .occupancy_o (occupancy_o),
        .stall_cnt_o (stall_cnt_o)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    typedef struct {
        bit            r, f, iv;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        bit            ordy;
        bit            chk;
        bit            e_ir, e_ov;
        logic [1:0]    e_occ;
        logic [CW-1:0] e_ctrl;
        logic [DW-1:0] e_data;
    } vec_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    ent_t          mdl_q[$];
    logic [DW-1:0] disp = '0;
    int unsigned   exp_stall = 0;
    bit            known = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, compare against the scoreboard, then advance it.
    task automatic step(input bit r, input bit f, input bit iv, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input bit ordy);
        bit   eir, in_fire, out_fire;
        ent_t e;
        @(negedge clk);
        rst_i = r; flush_i = f; in_valid_i = iv; in_data_i = d; in_ctrl_i = c;
        out_ready_i = ordy;
        #1;
        eir = !r && (mdl_q.size() < 2);
        check("in_ready", {63'd0, in_ready_o}, {63'd0, eir});
        if (known) begin
            check("out_valid", {63'd0, out_valid_o}, {63'd0, mdl_q.size() > 0});
            check("occupancy", {62'd0, occupancy_o}, 64'(mdl_q.size()));
            check("out_ctrl", 64'(out_ctrl_o), mdl_q.size() > 0 ? 64'(mdl_q[0].c) : 64'd0);
            check("out_data", 64'(out_data_o), mdl_q.size() > 0 ? 64'(mdl_q[0].d) : 64'(disp));
            check("stall_cnt", 64'(stall_cnt_o), 64'(exp_stall));
        end
        in_fire  = iv && eir;
        out_fire = (mdl_q.size() > 0) && ordy;
        if (r) begin
            mdl_q.delete();
            disp      = '0;
            exp_stall = 0;
            known     = 1'b1;
        end else begin
            if ((mdl_q.size() > 0) && !ordy && (exp_stall < STALL_MAX)) exp_stall++;
            if (out_fire) void'(mdl_q.pop_front());
            if (f) begin
                mdl_q.delete();
            end else if (in_fire) begin
                e.d = d;
                e.c = c;
                mdl_q.push_back(e);
            end
            if (mdl_q.size() > 0) disp = mdl_q[0].d;
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 1'b0, 1'b0, '0, '0, ordy);
    endtask

    vec_t tv[9];

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_ctrl_i = '0;
        out_ready_i = 1'b0;

        // r f iv data ctrl ordy chk ir ov occ ctrl data
        tv[0] = '{1, 0, 1, 48'h0,  8'hFF, 0, 0, 0, 0, 2'd0, 8'h00, 48'h0};
        tv[1] = '{1, 0, 1, 48'h0,  8'hFF, 0, 1, 0, 0, 2'd0, 8'h00, 48'h0};
        tv[2] = '{0, 0, 1, 48'hA,  8'h11, 0, 1, 1, 0, 2'd0, 8'h00, 48'h0};
        tv[3] = '{0, 0, 1, 48'hB,  8'h22, 0, 1, 1, 1, 2'd1, 8'h11, 48'hA};
        tv[4] = '{0, 0, 1, 48'hC,  8'h33, 0, 1, 0, 1, 2'd2, 8'h11, 48'hA};
        tv[5] = '{0, 0, 1, 48'hC,  8'h33, 1, 1, 0, 1, 2'd2, 8'h11, 48'hA};
        tv[6] = '{0, 0, 1, 48'hC,  8'h33, 1, 1, 1, 1, 2'd1, 8'h22, 48'hB};
        tv[7] = '{0, 0, 0, 48'h0,  8'h00, 1, 1, 1, 1, 2'd1, 8'h33, 48'hC};
        tv[8] = '{0, 0, 0, 48'h0,  8'h00, 0, 1, 1, 0, 2'd0, 8'h00, 48'hC};

        // Reset with junk input, then backpressure A,B with C held upstream.
        for (int i = 0; i < 9; i++) begin
            step(tv[i].r, tv[i].f, tv[i].iv, tv[i].d, tv[i].c, tv[i].ordy);
            if (tv[i].chk) begin
                check($sformatf("tv%0d.in_ready", i), {63'd0, in_ready_o}, {63'd0, tv[i].e_ir});
                check($sformatf("tv%0d.out_valid", i), {63'd0, out_valid_o},
                      {63'd0, tv[i].e_ov});
                check($sformatf("tv%0d.occ", i), {62'd0, occupancy_o}, {62'd0, tv[i].e_occ});
                check($sformatf("tv%0d.ctrl", i), 64'(out_ctrl_o), 64'(tv[i].e_ctrl));
                check($sformatf("tv%0d.data", i), 64'(out_data_o), 64'(tv[i].e_data));
            end
        end

        // Streaming 1..8 back-to-back with out_ready high.
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0, 1'b1, DW'(k), CW'(k), 1'b1);
            if (k > 1) check("stream_data", 64'(out_data_o), 64'(k - 1));
        end
        idle(1'b1);
        check("stream_last", 64'(out_data_o), 64'd8);
        idle(1'b1);

        // Flush while FULL with D presented the same cycle.
        step(1'b0, 1'b0, 1'b1, 48'h1111, 8'h01, 1'b0);
        step(1'b0, 1'b0, 1'b1, 48'h2222, 8'h02, 1'b0);
        step(1'b0, 1'b1, 1'b1, 48'hDDDD, 8'h0D, 1'b0);
        check("flush_full_occ_before", {62'd0, occupancy_o}, 64'd2);
        idle(1'b1);
        check("flush_full_occ", {62'd0, occupancy_o}, 64'd0);
        check("flush_full_ctrl", 64'(out_ctrl_o), 64'd0);
        idle(1'b1);
        check("flush_full_no_d", {63'd0, out_valid_o}, 64'd0);

        // Flush together with out_fire on head E.
        step(1'b0, 1'b0, 1'b1, 48'hEEEE, 8'h0E, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
        check("flush_fire_head", 64'(out_data_o), 64'hEEEE);
        idle(1'b1);
        check("flush_fire_empty", {62'd0, occupancy_o}, 64'd0);
        check("flush_fire_keep", 64'(out_data_o), 64'hEEEE);

        // Stall counter saturation, survives flush, cleared by reset.
        step(1'b0, 1'b0, 1'b1, 48'h5555, 8'h5A, 1'b0);
        for (int k = 0; k < 20; k++) idle(1'b0);
        check("stall_sat", 64'(stall_cnt_o), 64'(STALL_MAX));
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        idle(1'b0);
        check("stall_after_flush", 64'(stall_cnt_o), 64'(STALL_MAX));
        step(1'b1, 1'b0, 1'b1, '0, 8'hFF, 1'b0);
        step(1'b1, 1'b0, 1'b1, '0, 8'hFF, 1'b0);
        idle(1'b0);
        check("stall_after_rst", 64'(stall_cnt_o), 64'd0);

        // Random traffic against the scoreboard.
        for (int k = 0; k < 300; k++) begin
            step(1'b0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                 {$urandom(), $urandom()}, CW'($urandom()), $urandom_range(0, 2) != 0);
        end
        for (int k = 0; k < 3; k++) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
